branch_hazard_controller: RTL and testbench
===========================================

Name: branch_hazard_controller

Overview:
Sequences the stall and flush actions needed by ID-stage branch resolution. It detects data dependencies between a branch (or load-use consumer) in ID and in-flight producers in ID/EX and EX/MEM, and holds PC and IF/ID for the required number of cycles. It selects the forwarding sources for the ID-stage branch comparator and flushes IF/ID when a branch is taken. It sits beside the branch unit and hazard logic in ID, and drives the PC, IF/ID and ID/EX pipeline register controls.

Parameters:
CNT_W, 32, width of the saturating performance counters (stall cycles, flushes)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
ID_Branch  in  2  00 none, 01 beq, 10 bne (11 treated as none)
ID_UsesRs  in  1  ID instruction reads rs
ID_UsesRt  in  1  ID instruction reads rt
ID_rs  in  5  rs field of ID instruction
ID_rt  in  5  rt field of ID instruction
ID_EX_RegWrite  in  1  ID/EX instruction writes a register
ID_EX_MemRead  in  1  ID/EX instruction is a load
ID_EX_rd  in  5  ID/EX destination register (after RegDst mux)
EX_MEM_RegWrite  in  1  EX/MEM instruction writes a register
EX_MEM_MemRead  in  1  EX/MEM instruction is a load
EX_MEM_rd  in  5  EX/MEM destination register
MEM_WB_RegWrite  in  1  MEM/WB instruction writes a register
MEM_WB_rd  in  5  MEM/WB destination register
BranchTaken  in  1  PCSrc from branch unit, meaningful only when ID_Branch != 00
PCWrite  out  1  enable PC update
IF_ID_Write  out  1  enable IF/ID update
ID_EX_Bubble  out  1  zero ID/EX control fields (insert nop)
IF_ID_Flush  out  1  clear IF/ID (squash fetched instruction)
BrFwdA  out  2  comparator operand A source: 00 regfile, 01 EX/MEM ALU result, 10 MEM/WB result
BrFwdB  out  2  same for operand B
StallCount  out  CNT_W  total stall cycles since reset
FlushCount  out  CNT_W  total taken-branch flushes since reset

Behaviour:
- Reset applies on a clk edge while reset=1. It sets state RUN, remaining-stall counter 0, and both perf counters 0. While reset=1 the outputs are PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0, BrFwdA/B=00. Reset mid-stall abandons the stall.
- A match against a producer X on rs means X_RegWrite & X_rd!=0 & X_rd==ID_rs & ID_UsesRs. The rt match is analogous.
- Required stall length N, evaluated in RUN only. The first matching rule in this list wins:
  - branch & ID/EX load match -> N=2
  - branch & ID/EX non-load match -> N=1
  - branch & EX/MEM load match -> N=1
  - non-branch & ID/EX load match -> N=1
  - otherwise N=0
- FSM states RUN and STALL, plus a 2-bit remaining counter.
- RUN, N>0:
  - Outputs: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0.
  - BranchTaken is ignored.
  - Next state: load remaining=N-1. Go to STALL if N-1>0, else stay in RUN.
- RUN, N=0:
  - Outputs: PCWrite=1, IF_ID_Write=1, ID_EX_Bubble=0.
  - IF_ID_Flush = (ID_Branch∈{01,10}) & BranchTaken.
- STALL: PCWrite=0, IF_ID_Write=0, ID_EX_Bubble=1, IF_ID_Flush=0. Decrement remaining and return to RUN when it reaches 0. There is no re-evaluation during STALL.
- After leaving STALL, RUN re-evaluates N, so a newly arising hazard restarts the stall.
- The total stall for a load→branch dependency is exactly 2 cycles. ALU→branch and load-use each cost exactly 1 cycle.
- Forwarding is combinational and evaluated for operand A on ID_rs:
  - EX/MEM match with !EX_MEM_MemRead -> 01
  - else MEM/WB match -> 10
  - else 00
  - Operand B is the same on ID_rt. BrFwd is 00 whenever ID_Branch=00.
- StallCount increments on every cycle with PCWrite=0 outside reset. FlushCount increments on every cycle with IF_ID_Flush=1. Both saturate at all-ones, with no wrap.
- Register 0 never creates a hazard or forwards.

Decomposition:
- Shared package/include holds:
  - branch encodings BR_NONE=2'b00, BR_BEQ=2'b01, BR_BNE=2'b10
  - forward selects FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10
  - FSM state constants
- One natural sub-module: sat_counter (parameter width, synchronous reset, inc, saturating). It is instantiated twice for StallCount and FlushCount.

Test Plan:
- Load→branch: lw $1 in ID/EX, beq $1,$2 in ID -> two cycles of PCWrite=0/ID_EX_Bubble=1. Then in RUN with BrFwdA=10, StallCount=2.
- ALU→branch: add $3 in ID/EX, bne $3,$0 in ID -> one stall cycle. Then BrFwdA=01 (EX/MEM) and PCWrite=1.
- Taken branch, no hazard: beq $4,$5 with BranchTaken=1 -> IF_ID_Flush=1 for one cycle, FlushCount=1. With BranchTaken=0 -> no flush.
- Hazard plus taken in the same cycle: ALU match and BranchTaken=1 -> no flush while stalling. The flush is asserted only in the resolving RUN cycle.
- $0 and non-branch: lw $0 in ID/EX with a consumer of $0 -> no stall. lw $6 with an add using $6 -> exactly 1 stall and BrFwd=00.
- Reset mid-stall: assert reset in the first cycle of a 2-cycle load→branch stall -> next cycle RUN, counters 0, PCWrite=0 while reset is held. With CNT_W=2, 5 stall cycles give StallCount saturated at 3.

Source files
------------

// File: rtl/branch_hazard_controller_pkg.sv
// Shared encodings and helpers for the ID-stage branch hazard controller.
// Covers branch kinds, comparator forward selects, FSM states and the producer match.
package branch_hazard_controller_pkg;

    localparam logic [1:0] BR_NONE   = 2'b00;
    localparam logic [1:0] BR_BEQ    = 2'b01;
    localparam logic [1:0] BR_BNE    = 2'b10;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    // A producer hits a source operand only if it really writes a nonzero register the consumer reads.
    function automatic logic reg_match(input logic we, input logic [4:0] rd,
                                       input logic [4:0] src, input logic uses);
        return we && (rd != 5'd0) && (rd == src) && uses;
    endfunction

    // EX/MEM wins over MEM/WB as it is younger, but a load in EX/MEM has no data yet.
    function automatic logic [1:0] fwd_sel(input logic exm_hit, input logic exm_load,
                                           input logic wb_hit);
        if (exm_hit && !exm_load) return FWD_EXMEM;
        if (wb_hit)               return FWD_MEMWB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/branch_hazard_controller_sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + ONE;
    end

endmodule

// File: rtl/branch_hazard_controller.sv
// Stall/flush sequencing and comparator forwarding for branches resolved in ID.
// A RUN/STALL FSM with a small remaining-cycle counter holds PC and IF/ID.
module branch_hazard_controller
    import branch_hazard_controller_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       ID_Branch,
    input  logic             ID_UsesRs,
    input  logic             ID_UsesRt,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_EX_RegWrite,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_rd,
    input  logic             EX_MEM_RegWrite,
    input  logic             EX_MEM_MemRead,
    input  logic [4:0]       EX_MEM_rd,
    input  logic             MEM_WB_RegWrite,
    input  logic [4:0]       MEM_WB_rd,
    input  logic             BranchTaken,
    output logic             PCWrite,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic [1:0]       BrFwdA,
    output logic [1:0]       BrFwdB,
    output logic [CNT_W-1:0] StallCount,
    output logic [CNT_W-1:0] FlushCount
);

    state_t     state_q, state_d;
    logic [1:0] rem_q, rem_d;

    logic       is_branch;
    logic       idex_rs, idex_rt, exm_rs, exm_rt, wb_rs, wb_rt;
    logic       idex_hit, idex_load_hit, exm_load_hit;
    logic [1:0] need_n;

    always_comb begin
        is_branch = (ID_Branch == BR_BEQ) || (ID_Branch == BR_BNE);
        idex_rs   = reg_match(ID_EX_RegWrite,  ID_EX_rd,  ID_rs, ID_UsesRs);
        idex_rt   = reg_match(ID_EX_RegWrite,  ID_EX_rd,  ID_rt, ID_UsesRt);
        exm_rs    = reg_match(EX_MEM_RegWrite, EX_MEM_rd, ID_rs, ID_UsesRs);
        exm_rt    = reg_match(EX_MEM_RegWrite, EX_MEM_rd, ID_rt, ID_UsesRt);
        wb_rs     = reg_match(MEM_WB_RegWrite, MEM_WB_rd, ID_rs, ID_UsesRs);
        wb_rt     = reg_match(MEM_WB_RegWrite, MEM_WB_rd, ID_rt, ID_UsesRt);

        idex_hit      = idex_rs || idex_rt;
        idex_load_hit = idex_hit && ID_EX_MemRead;
        exm_load_hit  = (exm_rs || exm_rt) && EX_MEM_MemRead;

        // Priority order matters: a load feeding a branch must wait for MEM/WB.
        need_n = 2'd0;
        if (is_branch && idex_load_hit)       need_n = 2'd2;
        else if (is_branch && idex_hit)       need_n = 2'd1;
        else if (is_branch && exm_load_hit)   need_n = 2'd1;
        else if (!is_branch && idex_load_hit) need_n = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            rem_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rem_d        = rem_q;
        PCWrite      = 1'b0;
        IF_ID_Write  = 1'b0;
        ID_EX_Bubble = 1'b1;
        IF_ID_Flush  = 1'b0;
        if (!reset) begin
            case (state_q)
                ST_RUN: begin
                    if (need_n != 2'd0) begin
                        rem_d = need_n - 2'd1;
                        if (rem_d != 2'd0) state_d = ST_STALL;
                    end else begin
                        PCWrite      = 1'b1;
                        IF_ID_Write  = 1'b1;
                        ID_EX_Bubble = 1'b0;
                        IF_ID_Flush  = is_branch && BranchTaken;
                    end
                end
                ST_STALL: begin
                    rem_d = rem_q - 2'd1;
                    if (rem_d == 2'd0) state_d = ST_RUN;
                end
                default: state_d = ST_RUN;
            endcase
        end
    end

    always_comb begin
        BrFwdA = FWD_RF;
        BrFwdB = FWD_RF;
        if (!reset && is_branch) begin
            BrFwdA = fwd_sel(exm_rs, EX_MEM_MemRead, wb_rs);
            BrFwdB = fwd_sel(exm_rt, EX_MEM_MemRead, wb_rt);
        end
    end

    sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (!PCWrite),
        .count (StallCount)
    );

    sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (IF_ID_Flush),
        .count (FlushCount)
    );

endmodule

// File: tb/tb_branch_hazard_controller.sv
// Directed bench: a vector table for single-cycle decisions plus multi-cycle sequences.
module tb_branch_hazard_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  ID_Branch;
    logic        ID_UsesRs, ID_UsesRt;
    logic [4:0]  ID_rs, ID_rt;
    logic        ID_EX_RegWrite, ID_EX_MemRead;
    logic [4:0]  ID_EX_rd;
    logic        EX_MEM_RegWrite, EX_MEM_MemRead;
    logic [4:0]  EX_MEM_rd;
    logic        MEM_WB_RegWrite;
    logic [4:0]  MEM_WB_rd;
    logic        BranchTaken;

    logic        PCWrite, IF_ID_Write, ID_EX_Bubble, IF_ID_Flush;
    logic [1:0]  BrFwdA, BrFwdB;
    logic [31:0] StallCount, FlushCount;

    logic        s_PCWrite, s_IF_ID_Write, s_ID_EX_Bubble, s_IF_ID_Flush;
    logic [1:0]  s_BrFwdA, s_BrFwdB;
    logic [1:0]  s_StallCount, s_FlushCount;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_hazard_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .ID_Branch(ID_Branch), .ID_UsesRs(ID_UsesRs),
        .ID_UsesRt(ID_UsesRt), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_rd(EX_MEM_rd),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_rd(MEM_WB_rd), .BranchTaken(BranchTaken),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .ID_EX_Bubble(ID_EX_Bubble),
        .IF_ID_Flush(IF_ID_Flush), .BrFwdA(BrFwdA), .BrFwdB(BrFwdB),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    // Narrow-counter copy exercises saturation on the same stimulus.
    branch_hazard_controller #(.CNT_W(2)) dut_small (
        .clk(clk), .reset(reset), .ID_Branch(ID_Branch), .ID_UsesRs(ID_UsesRs),
        .ID_UsesRt(ID_UsesRt), .ID_rs(ID_rs), .ID_rt(ID_rt),
        .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead), .ID_EX_rd(ID_EX_rd),
        .EX_MEM_RegWrite(EX_MEM_RegWrite), .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_rd(EX_MEM_rd),
        .MEM_WB_RegWrite(MEM_WB_RegWrite), .MEM_WB_rd(MEM_WB_rd), .BranchTaken(BranchTaken),
        .PCWrite(s_PCWrite), .IF_ID_Write(s_IF_ID_Write), .ID_EX_Bubble(s_ID_EX_Bubble),
        .IF_ID_Flush(s_IF_ID_Flush), .BrFwdA(s_BrFwdA), .BrFwdB(s_BrFwdB),
        .StallCount(s_StallCount), .FlushCount(s_FlushCount)
    );

    typedef struct {
        logic [1:0] br;
        logic       urs;
        logic [4:0] rs;
        logic       urt;
        logic [4:0] rt;
        logic       exw;
        logic       exr;
        logic [4:0] exrd;
        logic       mw;
        logic       mr;
        logic [4:0] mrd;
        logic       ww;
        logic [4:0] wrd;
        logic       tk;
        logic       stall;
        logic       flush;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];
    vec_t s;

    task automatic apply(input vec_t v);
        ID_Branch = v.br;   ID_UsesRs = v.urs; ID_rs = v.rs; ID_UsesRt = v.urt; ID_rt = v.rt;
        ID_EX_RegWrite = v.exw; ID_EX_MemRead = v.exr; ID_EX_rd = v.exrd;
        EX_MEM_RegWrite = v.mw; EX_MEM_MemRead = v.mr; EX_MEM_rd = v.mrd;
        MEM_WB_RegWrite = v.ww; MEM_WB_rd = v.wrd; BranchTaken = v.tk;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic stall, input logic flush,
                            input logic [1:0] fa, input logic [1:0] fb);
        chk({tag, ".PCWrite"},      32'(PCWrite),      32'(!stall));
        chk({tag, ".IF_ID_Write"},  32'(IF_ID_Write),  32'(!stall));
        chk({tag, ".ID_EX_Bubble"}, 32'(ID_EX_Bubble), 32'(stall));
        chk({tag, ".IF_ID_Flush"},  32'(IF_ID_Flush),  32'(flush));
        chk({tag, ".BrFwdA"},       32'(BrFwdA),       32'(fa));
        chk({tag, ".BrFwdB"},       32'(BrFwdB),       32'(fb));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        //           br urs rs urt rt  exw exr exrd  mw mr mrd  ww wrd  tk  stall flush fa fb
        vecs[0]  = '{0, 0, 0, 0, 0,   0, 0, 0,    0, 0, 0,   0, 0,   0,  0, 0, 0, 0};
        vecs[1]  = '{1, 1, 4, 1, 5,   0, 0, 0,    0, 0, 0,   0, 0,   1,  0, 1, 0, 0};
        vecs[2]  = '{1, 1, 4, 1, 5,   0, 0, 0,    0, 0, 0,   0, 0,   0,  0, 0, 0, 0};
        vecs[3]  = '{2, 1, 4, 1, 5,   0, 0, 0,    0, 0, 0,   0, 0,   1,  0, 1, 0, 0};
        vecs[4]  = '{3, 1, 4, 1, 5,   0, 0, 0,    1, 0, 4,   0, 0,   1,  0, 0, 0, 0};
        vecs[5]  = '{1, 1, 1, 1, 2,   1, 1, 1,    0, 0, 0,   0, 0,   1,  1, 0, 0, 0};
        vecs[6]  = '{1, 1, 3, 1, 2,   1, 0, 3,    0, 0, 0,   0, 0,   1,  1, 0, 0, 0};
        vecs[7]  = '{1, 1, 7, 1, 2,   0, 0, 0,    1, 1, 7,   0, 0,   0,  1, 0, 0, 0};
        vecs[8]  = '{1, 1, 8, 1, 9,   0, 0, 0,    1, 0, 8,   1, 9,   0,  0, 0, 1, 2};
        vecs[9]  = '{1, 1, 8, 1, 8,   0, 0, 0,    1, 0, 8,   1, 8,   0,  0, 0, 1, 1};
        vecs[10] = '{1, 1, 8, 1, 9,   0, 0, 0,    1, 1, 8,   1, 8,   0,  1, 0, 2, 0};
        vecs[11] = '{0, 1, 6, 0, 0,   1, 1, 6,    0, 0, 0,   0, 0,   0,  1, 0, 0, 0};
        vecs[12] = '{0, 1, 0, 1, 0,   1, 1, 0,    0, 0, 0,   0, 0,   0,  0, 0, 0, 0};
        vecs[13] = '{1, 1, 0, 1, 0,   1, 1, 0,    1, 0, 0,   1, 0,   0,  0, 0, 0, 0};
        vecs[14] = '{0, 1, 6, 0, 0,   1, 0, 6,    0, 0, 0,   0, 0,   0,  0, 0, 0, 0};
        vecs[15] = '{1, 0, 5, 1, 2,   1, 1, 5,    0, 0, 0,   0, 0,   1,  0, 1, 0, 0};
        vecs[16] = '{1, 1, 1, 1, 2,   0, 1, 2,    0, 0, 0,   0, 0,   0,  0, 0, 0, 0};
        vecs[17] = '{1, 1, 1, 1, 10,  1, 0, 10,   0, 0, 0,   0, 0,   0,  1, 0, 0, 0};
        vecs[18] = '{0, 1, 6, 0, 0,   0, 0, 0,    1, 1, 6,   1, 6,   0,  0, 0, 0, 0};
        vecs[19] = '{2, 1, 3, 1, 9,   0, 0, 0,    0, 0, 0,   1, 9,   0,  0, 0, 0, 2};

        // Reset: hazard and forwardable inputs present, outputs must still be held.
        reset = 1'b1;
        apply('{1, 1, 1, 1, 2, 1, 1, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0});
        @(negedge clk);
        chk_outs("reset", 1'b1, 1'b0, 2'b00, 2'b00);
        step();
        @(negedge clk);
        chk("reset.StallCount", StallCount, 32'd0);
        chk("reset.FlushCount", FlushCount, 32'd0);

        for (int i = 0; i < NV; i++) begin
            do_reset();
            apply(vecs[i]);
            @(negedge clk);
            chk_outs($sformatf("vec%0d", i), vecs[i].stall, vecs[i].flush, vecs[i].fa, vecs[i].fb);
        end

        // Load -> branch: two stall cycles, then MEM/WB forward.
        do_reset();
        apply('{1, 1, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk); chk_outs("ldbr.c1", 1'b1, 1'b0, 2'b00, 2'b00);
        step();
        apply('{1, 1, 1, 1, 2, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk); chk_outs("ldbr.c2", 1'b1, 1'b0, 2'b00, 2'b00);
        step();
        apply('{1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0});
        @(negedge clk); chk_outs("ldbr.c3", 1'b0, 1'b0, 2'b10, 2'b00);
        chk("ldbr.StallCount", StallCount, 32'd2);
        chk("ldbr.s_StallCount", 32'(s_StallCount), 32'd2);

        // ALU -> branch: one stall, then EX/MEM forward.
        do_reset();
        apply('{2, 1, 3, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk); chk_outs("alubr.c1", 1'b1, 1'b0, 2'b00, 2'b00);
        step();
        apply('{2, 1, 3, 1, 0, 0, 0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk); chk_outs("alubr.c2", 1'b0, 1'b0, 2'b01, 2'b00);
        chk("alubr.StallCount", StallCount, 32'd1);

        // Taken branch with no hazard, then not taken.
        do_reset();
        apply('{1, 1, 4, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        @(negedge clk); chk_outs("taken.c1", 1'b0, 1'b1, 2'b00, 2'b00);
        step();
        BranchTaken = 1'b0;
        @(negedge clk); chk_outs("taken.c2", 1'b0, 1'b0, 2'b00, 2'b00);
        chk("taken.FlushCount", FlushCount, 32'd1);
        chk("taken.StallCount", StallCount, 32'd0);

        // Hazard and taken together: flush only in the resolving cycle.
        do_reset();
        apply('{1, 1, 3, 1, 2, 1, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        @(negedge clk); chk_outs("hztk.c1", 1'b1, 1'b0, 2'b00, 2'b00);
        step();
        chk("hztk.FlushCount0", FlushCount, 32'd0);
        apply('{1, 1, 3, 1, 2, 0, 0, 0, 1, 0, 3, 0, 0, 1, 0, 0, 0, 0});
        @(negedge clk); chk_outs("hztk.c2", 1'b0, 1'b1, 2'b01, 2'b00);
        step();
        chk("hztk.FlushCount1", FlushCount, 32'd1);

        // Load-use on a non-branch: exactly one stall, then free to go.
        do_reset();
        apply('{0, 1, 6, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk); chk_outs("ldus.c1", 1'b1, 1'b0, 2'b00, 2'b00);
        step();
        apply('{0, 1, 6, 0, 0, 0, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk); chk_outs("ldus.c2", 1'b0, 1'b0, 2'b00, 2'b00);
        chk("ldus.StallCount", StallCount, 32'd1);

        // Reset during a load -> branch stall abandons it.
        do_reset();
        apply('{1, 1, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk); chk_outs("rstmid.c1", 1'b1, 1'b0, 2'b00, 2'b00);
        step();
        reset = 1'b1;
        apply('{1, 1, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0});
        @(negedge clk); chk_outs("rstmid.c2", 1'b1, 1'b0, 2'b00, 2'b00);
        step();
        reset = 1'b0;
        apply('{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        @(negedge clk); chk_outs("rstmid.c3", 1'b0, 1'b0, 2'b00, 2'b00);
        chk("rstmid.StallCount", StallCount, 32'd0);
        chk("rstmid.FlushCount", FlushCount, 32'd0);

        // Saturation: five stall cycles and four flushes.
        do_reset();
        apply('{0, 1, 6, 0, 0, 1, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); chk_outs($sformatf("sat.c%0d", c), 1'b1, 1'b0, 2'b00, 2'b00);
            step();
        end
        chk("sat.StallCount", StallCount, 32'd5);
        chk("sat.s_StallCount", 32'(s_StallCount), 32'd3);
        do_reset();
        apply('{1, 1, 4, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0});
        for (int c = 0; c < 4; c++) step();
        chk("sat.FlushCount", FlushCount, 32'd4);
        chk("sat.s_FlushCount", 32'(s_FlushCount), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
